// File: rtl/idea_round_sequencer.sv
// Iterative IDEA encryption controller: generates the 52 subkeys on the fly, sequences
// eight passes through an external combinational round datapath, then applies the output transform.
module idea_round_sequencer #(
    parameter int ROUND_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  din,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [63:0]  dout,
    output logic [63:0]  round_in,
    output logic [95:0]  round_key,
    input  logic [63:0]  round_out
);

    localparam int LAT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  k_q, k_d;
    logic [2:0]    grp_cnt_q, grp_cnt_d;
    logic [2:0]    sub_cnt_q, sub_cnt_d;
    logic [2:0]    rnd_q, rnd_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [63:0]   round_in_q, round_in_d;
    logic [95:0]   round_key_q, round_key_d;
    logic [63:0]   dout_q, dout_d;
    logic          done_q, done_d;

    logic          emit;
    logic [15:0]   subkey;

    // Multiplication modulo 2^16+1 where the all-zero word stands for 2^16.
    function automatic logic [15:0] mul_mod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [15:0] lo;
        logic [15:0] hi;
        if (a == 16'd0) begin
            return 16'd1 - b;
        end else if (b == 16'd0) begin
            return 16'd1 - a;
        end
        p  = {16'd0, a} * {16'd0, b};
        lo = p[15:0];
        hi = p[31:16];
        if (lo >= hi) begin
            return lo - hi;
        end
        return lo - hi + 16'd1;
    endfunction

    assign subkey = k_q[127:112];
    assign emit   = (state_q == S_LOAD) || (state_q == S_FINAL);

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        k_d         = k_q;
        grp_cnt_d   = grp_cnt_q;
        sub_cnt_d   = sub_cnt_q;
        rnd_d       = rnd_q;
        lat_cnt_d   = lat_cnt_q;
        round_in_d  = round_in_q;
        round_key_d = round_key_q;
        dout_d      = dout_q;
        done_d      = 1'b0;

        // Eight emissions rotate K by 7*16 + 41 = 153, i.e. net 25 bits per group.
        if (emit) begin
            round_key_d = {round_key_q[79:0], subkey};
            grp_cnt_d   = grp_cnt_q + 3'd1;
            if (grp_cnt_q == 3'd7) begin
                k_d = {k_q[86:0], k_q[127:87]};
            end else begin
                k_d = {k_q[111:0], k_q[127:112]};
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    round_in_d = din;
                    k_d        = key;
                    grp_cnt_d  = 3'd0;
                    sub_cnt_d  = 3'd0;
                    rnd_d      = 3'd0;
                    lat_cnt_d  = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (sub_cnt_q == 3'd5) begin
                    sub_cnt_d = 3'd0;
                    lat_cnt_d = '0;
                    state_d   = S_ROUND;
                end else begin
                    sub_cnt_d = sub_cnt_q + 3'd1;
                end
            end
            S_ROUND: begin
                if (lat_cnt_q == LAT_W'(ROUND_LAT - 1)) begin
                    round_in_d = round_out;
                    lat_cnt_d  = '0;
                    if (rnd_q == 3'd7) begin
                        sub_cnt_d = 3'd0;
                        state_d   = S_FINAL;
                    end else begin
                        rnd_d   = rnd_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            S_FINAL: begin
                if (sub_cnt_q == 3'd3) begin
                    sub_cnt_d = 3'd0;
                    state_d   = S_OUT;
                end else begin
                    sub_cnt_d = sub_cnt_q + 3'd1;
                end
            end
            S_OUT: begin
                // Middle words swap back here, undoing the swap built into the last round.
                dout_d = {mul_mod(round_in_q[63:48], round_key_q[63:48]),
                          round_in_q[31:16] + round_key_q[47:32],
                          round_in_q[47:32] + round_key_q[31:16],
                          mul_mod(round_in_q[15:0], round_key_q[15:0])};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            grp_cnt_q   <= '0;
            sub_cnt_q   <= '0;
            rnd_q       <= '0;
            lat_cnt_q   <= '0;
            round_in_q  <= '0;
            round_key_q <= '0;
            dout_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            grp_cnt_q   <= grp_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            rnd_q       <= rnd_d;
            lat_cnt_q   <= lat_cnt_d;
            round_in_q  <= round_in_d;
            round_key_q <= round_key_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
        end
    end

    // done is registered, so the done cycle is already IDLE yet still counts as busy.
    assign busy      = (state_q != S_IDLE) || done_q;
    assign done      = done_q;
    assign dout      = dout_q;
    assign round_in  = round_in_q;
    assign round_key = round_key_q;

endmodule
